// File: rtl/square.sv
// Sequential unsigned squarer: latches x_bi on start_i and returns x*x on y_bo
// after W shift-add steps plus one result-write cycle.
module square #(
  parameter int unsigned W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [W-1:0]     x_bi,
  output logic [2*W-1:0]   y_bo,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic {
    IDLE,
    WORK
  } state_t;

  state_t           state, state_nxt;
  logic [2*W-1:0]   a;
  logic [W-1:0]     b;
  logic [2*W-1:0]   acc;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start_i)    state_nxt = WORK;
      WORK: if (cnt == '0)  state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  assign busy_o = (state == WORK);

  // Fixed W steps with no early exit, so latency never depends on the operand.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      a      <= '0;
      b      <= '0;
      acc    <= '0;
      cnt    <= '0;
      y_bo   <= '0;
      done_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            a   <= {{W{1'b0}}, x_bi};
            b   <= x_bi;
            acc <= '0;
            cnt <= CW'(W);
          end
        end
        WORK: begin
          if (cnt != '0) begin
            if (b[0]) acc <= acc + a;
            a   <= a << 1;
            b   <= b >> 1;
            cnt <= cnt - CW'(1);
          end else begin
            y_bo   <= acc;
            done_o <= 1'b1;
          end
        end
        default: done_o <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/square.md
# square

Sequential unsigned squarer: latches a W-bit operand on a start strobe and returns its 2W-bit square after a fixed number of shift-add cycles. It is the inverse of the team's sequential integer square-root unit. Its W=8 to 16-bit output pairs with that unit's 16-bit input and 8-bit result. It sits beside the root unit in the arithmetic lab datapath, where it produces root test vectors and verifies root results in the loop.

## Interface
- W, default 8: operand width in bits; result width is 2W. Legal range is 2..16.
- clk_i, input, 1: clock; all state updates on the rising edge.
- rst_i, input, 1: reset, asynchronous and active-low; the block is held in reset while rst_i = 0.
- start_i, input, 1: request strobe; sampled only in IDLE.
- x_bi, input, W: operand; sampled on the same edge as start_i.
- y_bo, output, 2W: registered result, x*x; holds its value until the next result is written.
- busy_o, output, 1: high while a computation is in progress (state is WORK).
- done_o, output, 1: one-cycle pulse, high in the cycle y_bo first shows a new result.

## Operation
- Internal registers:
  - a, 2W bits: shifted multiplicand.
  - b, W bits: multiplier bits still to process.
  - acc, 2W bits: partial sum.
  - cnt, ceil(log2(W+1)) bits: remaining steps.
  - state: one of IDLE or WORK.
- IDLE:
  - If start_i = 1: a <= zero-extended x_bi, b <= x_bi, acc <= 0, cnt <= W, state <= WORK.
  - If start_i = 0: no change.
  - done_o <= 0 on every IDLE edge.
- WORK, when cnt != 0:
  - If b[0] = 1, acc <= acc + a, computed modulo 2^2W. The sum never exceeds (2^W−1)^2, so it cannot overflow.
  - a <= a << 1; b <= b >> 1; cnt <= cnt − 1.
- WORK, when cnt == 0: y_bo <= acc, done_o <= 1, state <= IDLE.
- No early termination; latency is independent of the operand value, zero included.
- start_i and x_bi are ignored while in WORK. Changing x_bi mid-computation has no effect on the result.
- busy_o is decoded combinationally from state; y_bo and done_o are registers.
- Reset (rst_i = 0, asynchronous) forces:
  - state = IDLE, y_bo = 0, done_o = 0, busy_o = 0;
  - a, b, acc and cnt to 0.
- Reset mid-computation discards the operation; no done_o pulse is produced for it.

## Timing
- Edge T0: start_i = 1 sampled in IDLE; busy_o is high from just after T0.
- Edges T0+1 … T0+W: W add/shift steps.
- Edge T0+W+1: y_bo is valid, done_o = 1, busy_o = 0 (back in IDLE).
- Start-to-result latency is W+1 cycles; busy_o is high for exactly W+1 cycles.
- Back-to-back operation: start_i = 1 in the done_o cycle is accepted at edge T0+W+2. The issue interval is W+2 cycles.
- If start_i is held high continuously, a new operation begins every W+2 cycles. Each one re-samples x_bi at its accept edge.
- Release of rst_i: the first active edge after rst_i rises may accept start_i.
- done_o is never high for two consecutive cycles.

## Test plan
- Reset: assert rst_i = 0 between clock edges -> y_bo = 0, busy_o = 0 and done_o = 0 immediately, without waiting for a clock edge.
- Basic values, W = 8: x_bi = 13 -> y_bo = 169; x_bi = 0 -> y_bo = 0; x_bi = 255 -> y_bo = 0xFE01. In each case:
  - done_o pulses exactly 9 cycles after the start edge;
  - busy_o is high for exactly those 9 cycles.
- Busy rejection:
  - start x_bi = 10; at T0+3, drive start_i = 1 with x_bi = 200 -> result is 100, and no second operation begins.
  - Hold start_i high continuously with x_bi = 7 -> a 49 result every 10 cycles.
- Reset mid-operation:
  - start x_bi = 100; pull rst_i low at T0+4 -> no done_o, y_bo = 0.
  - After release, start x_bi = 3 -> y_bo = 9 at T0'+9.
- Exhaustive and round trip: sweep x_bi = 0..255 in back-to-back mode -> every y_bo equals x*x. Then, for each result y:
  - floor(sqrt(y)) = x;
  - y + 2x, fed to a floor square root, returns x.
- Parameter check, W = 4: x_bi = 15 -> y_bo = 225, latency 5 cycles, busy_o high for 5 cycles.
